frame_sequencer: RTL and testbench
==================================

# frame_sequencer

Sequences the receive path downstream of `synchronization`: it discards samples until a short-preamble detection ends (`s_last`), then latches that frame's coarse frequency-offset estimate. It skips a fixed guard of samples, forwards exactly one frame's worth of samples to the demodulator with `m_last` on the final one, then holds off before re-arming detection. It is the single owner of the "searching / in-frame" decision for the receive chain.

## Interface
- `SKIP`, 16: samples dropped after detection, before forwarding starts (range 0..65535).
- `HOLDOFF`, 32: samples dropped after frame end or abort, before re-arming (range 0..65535).
- `LENGTH_WIDTH`, 16: width of `frame_length` and the internal sample counter.

Ports:
- `clk` in 1: clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `s_valid` in 1: sample beat from synchronization.
- `s_ready` out 1: beat accepted when `s_valid && s_ready`.
- `s_data` in 32: {Q[31:16], I[15:0]} sample.
- `s_user` in 32: signed frequency-offset estimate.
- `s_last` in 1: end of detected preamble.
- `frame_length` in LENGTH_WIDTH: samples per frame; sampled on lock.
- `abort` in 1: synchronous request to terminate the current frame.
- `m_valid` out 1: output beat.
- `m_ready` in 1: output beat accepted when `m_valid && m_ready`.
- `m_data` out 32: forwarded sample.
- `m_user` out 32: frequency offset latched at lock, constant for the whole frame.
- `m_last` out 1: final beat of the frame.
- `busy` out 1: high in any state other than SEARCH.
- `locked` out 1: one-cycle pulse on detection.
- `aborted` out 1: one-cycle pulse when a frame is truncated.

## Operation
States: SEARCH, SKIP, FORWARD, HOLD. An accepted beat means `s_valid && s_ready`.

- **SEARCH:** `s_ready`=1, all beats dropped.
  - Accepted beat with `s_last`=1: latch `s_user` into the m_user register and `frame_length` into the length register, pulse `locked`.
  - Next state: SKIP if SKIP>0; else FORWARD if length>0; else HOLD.
- **SKIP:** `s_ready`=1; drop SKIP accepted beats, then go to FORWARD (or to HOLD if length==0). `s_last` is ignored.
- **FORWARD:**
  - `s_ready` = !m_valid || m_ready, a single registered output stage.
  - Each accepted beat loads `m_data`; `m_last`=1 on the length-th beat.
  - `s_last` is ignored and never restarts the frame.
  - After the last beat is accepted by the output register, the state moves to HOLD. The state leaves HOLD only through its own counter; the final beat drains downstream independently.
- **HOLD:** `s_ready`=1; drop HOLDOFF accepted beats (zero means leave immediately, next cycle), then go to SEARCH.
- **Abort:**
  - `abort`=1 in SKIP: go to HOLD, pulse `aborted`.
  - `abort`=1 in FORWARD: `s_ready` forced to 0 that cycle. A held output beat is emitted unchanged (no `m_last` is added). The state goes to HOLD and `aborted` pulses.
  - `abort` in SEARCH or HOLD is ignored.
  - `abort` has priority over a simultaneous final beat: that beat is not accepted.
- **Counters:** a single down-counter of LENGTH_WIDTH bits, reloaded on each state entry. It is not wrapped; zero is detected before decrement.
- **Output stability:** `m_data`, `m_last` and `m_user` are stable while `m_valid && !m_ready`. `m_user` changes only at lock.

## Timing
- Reset (asynchronous assert, released synchronously to `clk`):
  - State is SEARCH.
  - `m_valid`, `m_last`, `locked`, `aborted` = 0.
  - `m_data`, `m_user` = 0; counter = 0.
  - `busy` = 0; `s_ready` = 1.
- A reset mid-frame discards the held beat with no `m_last`.
- Latency: an accepted input beat in FORWARD appears on `m_valid` the next cycle.
- Throughput: 1 beat/cycle with `m_ready` held at 1.
- `locked` is high in the cycle after the `s_last` beat; `busy` rises the same cycle.
- A SEARCH-detect to first forwarded input beat takes exactly SKIP accepted beats in between.
- `s_ready` is combinational from state, `m_valid`, `m_ready` and `abort`. There is no combinational path from `s_valid` to `s_ready`.

## Structure
- Shared package `wiphy_pkg`:
  - `frame_state_t` enum {SEARCH, SKIP, FORWARD, HOLD}.
  - The sample-beat width constant (32).
- One sub-module, `sample_register`: a single-entry valid/ready register carrying {last, data}. It is reusable for the FORWARD output stage.
- The FSM and counter live in `frame_sequencer`.

## Test plan
- **Basic frame:** SKIP=2, HOLDOFF=2, `frame_length`=4, `s_user`=0x00000123 on the `s_last` beat, samples 0..9 in continuous stream.
  - `locked` pulses once; samples 3..6 are forwarded.
  - `m_last` only on sample 6; `m_user`=0x123 throughout.
  - `busy` falls after 2 further drops.
- **Backpressure:** same frame with `m_ready` toggling 1,0,0,1.
  - `m_data`/`m_last` are held stable while stalled.
  - No beat is lost or duplicated.
  - `s_ready` is 0 exactly when `m_valid && !m_ready`.
- **Ignored `s_last`:** `s_last`=1 on the 2nd forwarded beat with `s_user`=0x7 → frame continues to length 4; `m_user` is unchanged; no second `locked`.
- **Zero cases:** SKIP=0, `frame_length`=0 → no `m_valid`; FSM goes SEARCH→HOLD→SEARCH; `locked` pulses.
- **Abort:** `abort` asserted on the 2nd forwarded beat with `m_ready`=0.
  - The held beat 1 is emitted with `m_last`=0.
  - `aborted` pulses; HOLD is entered; no further output.
- **Reset mid-frame:** `reset_n` low during FORWARD with `m_valid`=1.
  - Outputs go to their reset values immediately.
  - After release, a new detection runs a clean frame.

Source files
------------

// File: rtl/wiphy_pkg.sv
// Shared receive-chain types: frame sequencing states and the sample beat width.
package wiphy_pkg;
    localparam int SAMPLE_W = 32;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        SKIP    = 2'd1,
        FORWARD = 2'd2,
        HOLD    = 2'd3
    } frame_state_t;
endpackage

// File: rtl/sample_register.sv
// Single-entry valid/ready register stage; data is held while o_valid && !i_ready.
module sample_register
    import wiphy_pkg::*;
#(
    parameter int W = SAMPLE_W + 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_data
);
    logic         r_valid;
    logic [W-1:0] r_data;

    assign o_ready = !r_valid || i_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (o_ready) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= i_data;
            end
        end
    end
endmodule

// File: rtl/frame_sequencer.sv
// Receive-path frame sequencer: waits for preamble detection, skips a guard,
// forwards one frame with m_last on its final beat, then holds off before re-arming.
module frame_sequencer #(
    parameter int unsigned SKIP         = 16,
    parameter int unsigned HOLDOFF      = 32,
    parameter int unsigned LENGTH_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [31:0]             s_data,
    input  logic [31:0]             s_user,
    input  logic                    s_last,
    input  logic [LENGTH_WIDTH-1:0] frame_length,
    input  logic                    abort,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [31:0]             m_data,
    output logic [31:0]             m_user,
    output logic                    m_last,
    output logic                    busy,
    output logic                    locked,
    output logic                    aborted,
    output wiphy_pkg::frame_state_t dbg_state
);
    localparam logic [LENGTH_WIDTH-1:0] SKIP_CNT = LENGTH_WIDTH'(SKIP);
    localparam logic [LENGTH_WIDTH-1:0] HOLD_CNT = LENGTH_WIDTH'(HOLDOFF);
    localparam logic [LENGTH_WIDTH-1:0] ONE      = LENGTH_WIDTH'(1);

    wiphy_pkg::frame_state_t r_state;
    logic [LENGTH_WIDTH-1:0] r_count;
    logic [LENGTH_WIDTH-1:0] r_len;
    logic [31:0]             r_user;
    logic                    r_locked;
    logic                    r_aborted;

    logic        w_accept;
    logic        w_fwd_load;
    logic        w_fwd_last;
    logic        w_out_ready;
    logic [32:0] w_out_data;

    // Beats transfer on a cycle with valid && ready; ready never looks at valid,
    // and a valid beat holds its payload until it is taken.
    always_comb begin
        s_ready = 1'b1;
        if (r_state == wiphy_pkg::FORWARD) begin
            s_ready = !abort && w_out_ready;
        end
    end

    assign w_accept   = s_valid && s_ready;
    assign w_fwd_load = w_accept && (r_state == wiphy_pkg::FORWARD);
    assign w_fwd_last = (r_count == ONE);

    sample_register #(.W(33)) u_out_reg (
        .clk     (clk),
        .reset_n (reset_n),
        .i_valid (w_fwd_load),
        .o_ready (w_out_ready),
        .i_data  ({w_fwd_last, s_data}),
        .o_valid (m_valid),
        .i_ready (m_ready),
        .o_data  (w_out_data)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= wiphy_pkg::SEARCH;
            r_count   <= '0;
            r_len     <= '0;
            r_user    <= '0;
            r_locked  <= 1'b0;
            r_aborted <= 1'b0;
        end else begin
            r_locked  <= 1'b0;
            r_aborted <= 1'b0;
            case (r_state)
                wiphy_pkg::SEARCH: begin
                    if (w_accept && s_last) begin
                        r_user   <= s_user;
                        r_len    <= frame_length;
                        r_locked <= 1'b1;
                        if (SKIP_CNT != '0) begin
                            r_state <= wiphy_pkg::SKIP;
                            r_count <= SKIP_CNT;
                        end else if (frame_length != '0) begin
                            r_state <= wiphy_pkg::FORWARD;
                            r_count <= frame_length;
                        end else begin
                            r_state <= wiphy_pkg::HOLD;
                            r_count <= HOLD_CNT;
                        end
                    end
                end
                wiphy_pkg::SKIP: begin
                    if (abort) begin
                        r_state   <= wiphy_pkg::HOLD;
                        r_count   <= HOLD_CNT;
                        r_aborted <= 1'b1;
                    end else if (w_accept) begin
                        if (r_count == ONE) begin
                            if (r_len != '0) begin
                                r_state <= wiphy_pkg::FORWARD;
                                r_count <= r_len;
                            end else begin
                                r_state <= wiphy_pkg::HOLD;
                                r_count <= HOLD_CNT;
                            end
                        end else begin
                            r_count <= r_count - ONE;
                        end
                    end
                end
                wiphy_pkg::FORWARD: begin
                    if (abort) begin
                        r_state   <= wiphy_pkg::HOLD;
                        r_count   <= HOLD_CNT;
                        r_aborted <= 1'b1;
                    end else if (w_accept) begin
                        if (w_fwd_last) begin
                            r_state <= wiphy_pkg::HOLD;
                            r_count <= HOLD_CNT;
                        end else begin
                            r_count <= r_count - ONE;
                        end
                    end
                end
                wiphy_pkg::HOLD: begin
                    // A zero holdoff leaves without waiting for any beat.
                    if (r_count == '0) begin
                        r_state <= wiphy_pkg::SEARCH;
                    end else if (w_accept) begin
                        if (r_count == ONE) begin
                            r_state <= wiphy_pkg::SEARCH;
                        end
                        r_count <= r_count - ONE;
                    end
                end
                default: begin
                    r_state <= wiphy_pkg::SEARCH;
                    r_count <= '0;
                end
            endcase
        end
    end

    assign m_data    = w_out_data[31:0];
    assign m_last    = w_out_data[32];
    assign m_user    = r_user;
    assign busy      = (r_state != wiphy_pkg::SEARCH);
    assign locked    = r_locked;
    assign aborted   = r_aborted;
    assign dbg_state = r_state;
endmodule

// File: tb/tb_frame_sequencer.sv
// Bench for frame_sequencer: directed frames plus a randomized stream checked
// against an index-arithmetic frame model.
module tb_frame_sequencer;
    localparam int A_SKIP = 2;
    localparam int A_HOLD = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        s_valid = 1'b0, s_last = 1'b0, abort = 1'b0, m_ready = 1'b1;
    logic [31:0] s_data = '0, s_user = '0;
    logic [15:0] frame_length = '0;
    logic        s_ready, m_valid, m_last, busy, locked, aborted;
    logic [31:0] m_data, m_user;
    wiphy_pkg::frame_state_t dbg_state;

    logic        b_s_valid = 1'b0, b_s_last = 1'b0, b_abort = 1'b0, b_m_ready = 1'b1;
    logic [31:0] b_s_data = '0, b_s_user = '0;
    logic [15:0] b_frame_length = '0;
    logic        b_s_ready, b_m_valid, b_m_last, b_busy, b_locked, b_aborted;
    logic [31:0] b_m_data, b_m_user;
    wiphy_pkg::frame_state_t b_dbg_state;

    frame_sequencer #(.SKIP(A_SKIP), .HOLDOFF(A_HOLD), .LENGTH_WIDTH(16)) dut_a (
        .clk(clk), .reset_n(reset_n), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_user(s_user), .s_last(s_last), .frame_length(frame_length),
        .abort(abort), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_user(m_user), .m_last(m_last), .busy(busy), .locked(locked),
        .aborted(aborted), .dbg_state(dbg_state)
    );

    frame_sequencer #(.SKIP(0), .HOLDOFF(0), .LENGTH_WIDTH(16)) dut_b (
        .clk(clk), .reset_n(reset_n), .s_valid(b_s_valid), .s_ready(b_s_ready),
        .s_data(b_s_data), .s_user(b_s_user), .s_last(b_s_last), .frame_length(b_frame_length),
        .abort(b_abort), .m_valid(b_m_valid), .m_ready(b_m_ready), .m_data(b_m_data),
        .m_user(b_m_user), .m_last(b_m_last), .busy(b_busy), .locked(b_locked),
        .aborted(b_aborted), .dbg_state(b_dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int lock_cnt = 0;
    int abort_cnt = 0;
    int b_mv_cnt = 0;
    int mr_mode  = 0;

    logic [64:0] exp_q[$];
    logic [31:0] q_data[$];
    logic [31:0] q_user[$];
    logic        q_last[$];
    logic [15:0] q_len[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    endtask

    // m_ready driver: 0 always ready, 1 pattern 1,0,0,1, 2 random, 3 stalled
    initial begin
        logic [3:0] pat;
        int ph;
        pat = 4'b1001;
        ph  = 0;
        forever begin
            @(posedge clk);
            #1;
            case (mr_mode)
                0: m_ready = 1'b1;
                1: begin m_ready = pat[ph]; ph = (ph + 1) % 4; end
                2: m_ready = 1'($urandom_range(0, 1));
                default: m_ready = 1'b0;
            endcase
        end
    end

    // Monitor and scoreboard, sampled on the falling edge.
    initial begin
        logic        prev_stall;
        logic [31:0] prev_data;
        logic        prev_last;
        logic        exp_rdy;
        logic [64:0] e;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_last  = 1'b0;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (locked) lock_cnt++;
                if (aborted) abort_cnt++;
                if (b_m_valid) b_mv_cnt++;
                exp_rdy = (dbg_state == wiphy_pkg::FORWARD) ? (!abort && (!m_valid || m_ready)) : 1'b1;
                check_eq("s_ready", s_ready, exp_rdy);
                if (prev_stall) begin
                    check_eq("stall_valid", m_valid, 1);
                    check_eq("stall_data", m_data, prev_data);
                    check_eq("stall_last", m_last, prev_last);
                end
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        check_eq("extra_beat", m_valid & m_ready, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check_eq("m_data", m_data, e[31:0]);
                        check_eq("m_user", m_user, e[63:32]);
                        check_eq("m_last", m_last, e[64]);
                    end
                end
                prev_stall = m_valid && !m_ready;
                prev_data  = m_data;
                prev_last  = m_last;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    task automatic send_beat(input logic [31:0] d, input logic l, input logic [31:0] u, input logic [15:0] fl);
        bit got;
        got = 0;
        s_data = d; s_last = l; s_user = u; frame_length = fl; s_valid = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (s_ready) begin got = 1; break; end
        end
        if (!got) check_eq("send_timeout", got, 1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // Frame model: a detection at index d forwards beats d+1+SKIP .. d+SKIP+len
    // and the search resumes at index d+1+SKIP+len+HOLDOFF.
    task automatic build_expected(output int n_lock);
        int i, d, len, idx;
        n_lock = 0;
        i = 0;
        while (i < q_data.size()) begin
            if (q_last[i]) begin
                d = i;
                n_lock++;
                len = int'(q_len[d]);
                for (int k = 0; k < len; k++) begin
                    idx = d + 1 + A_SKIP + k;
                    if (idx < q_data.size()) exp_q.push_back({(k == len - 1), q_user[d], q_data[idx]});
                end
                i = d + 1 + A_SKIP + len + A_HOLD;
            end else begin
                i++;
            end
        end
    endtask

    task automatic fill_frame(input logic [31:0] base, input logic [31:0] user, input bit second_last);
        q_data.delete(); q_user.delete(); q_last.delete(); q_len.delete();
        for (int i = 0; i < 10; i++) begin
            q_data.push_back(base + 32'(i));
            q_last.push_back((i == 0) || (second_last && i == 4));
            q_user.push_back(i == 0 ? user : (i == 4 ? 32'h7 : $urandom));
            q_len.push_back(16'd4);
        end
    endtask

    task automatic run_stream(input bit gaps, input bit basic_hooks);
        int n_lock;
        build_expected(n_lock);
        lock_cnt = 0;
        for (int i = 0; i < q_data.size(); i++) begin
            send_beat(q_data[i], q_last[i], q_user[i], q_len[i]);
            if (basic_hooks) begin
                if (i == 0) begin check_eq("lock_pulse", locked, 1); check_eq("busy_rise", busy, 1); end
                if (i == 1) check_eq("lock_end", locked, 0);
                if (i == 7) check_eq("busy_hold", busy, 1);
                if (i == 8) check_eq("busy_fall", busy, 0);
            end
            if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        for (int t = 0; t < 500 && exp_q.size() != 0; t++) @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        check_eq("drain", exp_q.size(), 0);
        check_eq("lock_count", lock_cnt, n_lock);
        check_eq("idle_busy", busy, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_m_valid", m_valid, 0);
        check_eq("rst_m_last", m_last, 0);
        check_eq("rst_locked", locked, 0);
        check_eq("rst_aborted", aborted, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_s_ready", s_ready, 1);
        check_eq("rst_m_user", m_user, 0);
        check_eq("rst_b_s_ready", b_s_ready, 1);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // basic frame, continuous stream
        fill_frame(32'd0, 32'h123, 0);
        run_stream(0, 1);
        check_eq("basic_user", m_user, 32'h123);

        // backpressure 1,0,0,1
        mr_mode = 1;
        fill_frame(32'd0, 32'h123, 0);
        run_stream(0, 0);
        mr_mode = 0;

        // s_last inside the frame is ignored
        fill_frame(32'h40, 32'h123, 1);
        run_stream(0, 0);
        check_eq("ignored_last_user", m_user, 32'h123);

        // zero skip, zero length, zero holdoff
        b_s_user = 32'h55; b_s_last = 1'b1; b_s_valid = 1'b1;
        @(posedge clk);
        #1;
        b_s_valid = 1'b0; b_s_last = 1'b0;
        check_eq("zero_locked", b_locked, 1);
        check_eq("zero_busy", b_busy, 1);
        @(posedge clk);
        #1;
        check_eq("zero_busy_fall", b_busy, 0);
        check_eq("zero_lock_end", b_locked, 0);
        check_eq("zero_user", b_m_user, 32'h55);

        // abort on the 2nd forwarded beat with the output stalled
        mr_mode = 3;
        lock_cnt = 0; abort_cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        send_beat(32'd0, 1'b1, 32'h123, 16'd4);
        for (int i = 1; i < 4; i++) send_beat(32'(i), 1'b0, $urandom, 16'd4);
        exp_q.push_back({1'b0, 32'h123, 32'd3});
        s_data = 32'd4; s_valid = 1'b1; abort = 1'b1;
        @(negedge clk);
        check_eq("abort_s_ready", s_ready, 0);
        @(posedge clk);
        #1;
        abort = 1'b0; s_valid = 1'b0;
        check_eq("abort_pulse", aborted, 1);
        check_eq("abort_hold", dbg_state, wiphy_pkg::HOLD);
        check_eq("abort_held_valid", m_valid, 1);
        mr_mode = 0;
        repeat (4) @(posedge clk);
        #1;
        check_eq("abort_drain", exp_q.size(), 0);
        for (int i = 5; i < 9; i++) send_beat(32'(i), 1'b0, $urandom, 16'd4);
        repeat (3) @(posedge clk);
        #1;
        check_eq("abort_idle", busy, 0);
        check_eq("abort_count", abort_cnt, 1);
        check_eq("abort_lock_count", lock_cnt, 1);

        // reset while a beat is held in FORWARD
        mr_mode = 3;
        repeat (2) @(posedge clk);
        #1;
        send_beat(32'd0, 1'b1, 32'h999, 16'd4);
        for (int i = 1; i < 4; i++) send_beat(32'h80 + 32'(i), 1'b0, $urandom, 16'd4);
        check_eq("pre_rst_valid", m_valid, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("mid_rst_valid", m_valid, 0);
        check_eq("mid_rst_last", m_last, 0);
        check_eq("mid_rst_data", m_data, 0);
        check_eq("mid_rst_user", m_user, 0);
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_s_ready", s_ready, 1);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        mr_mode = 0;
        fill_frame(32'h100, 32'h456, 0);
        run_stream(0, 0);

        // randomized stream with gaps and random backpressure
        mr_mode = 2;
        q_data.delete(); q_user.delete(); q_last.delete(); q_len.delete();
        for (int i = 0; i < 300; i++) begin
            q_data.push_back($urandom);
            q_last.push_back($urandom_range(0, 5) == 0);
            q_user.push_back($urandom);
            q_len.push_back(16'($urandom_range(0, 6)));
        end
        for (int i = 0; i < 16; i++) begin
            q_data.push_back($urandom); q_last.push_back(1'b0);
            q_user.push_back($urandom); q_len.push_back(16'd3);
        end
        run_stream(1, 0);
        mr_mode = 0;

        check_eq("b_never_valid", b_mv_cnt, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
